// File: rtl/memory_stage_pkg.sv
// ============================================================================
// memory_stage_pkg : address map, ExcCode values and E/M register layout
// Revision 1.0
// ============================================================================
`default_nettype none

package memory_stage_pkg;

  localparam logic [31:0] DM_END    = 32'h0000_3000;
  localparam logic [31:0] TC0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] IG_BASE   = 32'h0000_7F20;
  localparam logic [31:0] EXC_PC    = 32'h0000_4180;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] TC_SPAN   = 32'd12;
  localparam logic [31:0] IG_SPAN   = 32'd4;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    MT_WORD = 2'd0,
    MT_HALF = 2'd1,
    MT_BYTE = 2'd2
  } mem_type_t;

  typedef struct packed {
    logic        delay;
    logic [4:0]  exc_code;
    logic [31:0] result;
    logic        addr_ovf;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic        reg_write;
    logic [4:0]  a3;
    logic        mem_rd;
    logic        mem_wr;
    mem_type_t   mem_type;
    logic        ld_signed;
  } em_reg_t;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] span);
    return (addr >= base) && (addr < base + span);
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_stage_data_ext.sv
// ============================================================================
// memory_stage_data_ext : load lane select plus sign/zero extension
// Revision 1.0
// ============================================================================
`default_nettype none

module memory_stage_data_ext
  import memory_stage_pkg::*;
(
  input  logic [1:0]  addr_low,
  input  logic [1:0]  mem_type,
  input  logic        ld_signed,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr_low, 3'b000} +: 8];
  assign half_lane = addr_low[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = rdata;
    case (mem_type)
      MT_HALF: ld_data = {{16{ld_signed & half_lane[15]}}, half_lane};
      MT_BYTE: ld_data = {{24{ld_signed & byte_lane[7]}}, byte_lane};
      default: ld_data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage : MIPS M stage - E/M register, data-memory interface, AdEL/AdES
// Revision 1.0
// ============================================================================
`default_nettype none

module memory_stage
  import memory_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        bubble_E,
  input  logic        Delay_E_i,
  input  logic [4:0]  ExcCode_E_i,
  input  logic [31:0] result_E_i,
  input  logic        addr_ovf_E_i,
  input  logic [31:0] RD2_E_i,
  input  logic [31:0] PCn_E_i,
  input  logic        regWrite_E_i,
  input  logic [4:0]  A3_E_i,
  input  logic        mem_rd_E_i,
  input  logic        mem_wr_E_i,
  input  logic [1:0]  mem_type_E_i,
  input  logic        ld_signed_E_i,
  input  logic [31:0] W_forward,
  input  logic        RD2_M_fwd,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  output logic [31:0] result_M_o,
  output logic [31:0] ld_data_M_o,
  output logic        mem_rd_M_o,
  output logic        Delay_M_o,
  output logic [31:0] PCn_M_o,
  output logic        regWrite_M_o,
  output logic [4:0]  A3_M_o,
  output logic [4:0]  ExcCode_M_o
);

  em_reg_t em;

  always_ff @(posedge clk) begin
    if (reset) begin
      em    <= '0;
      em.pc <= RESET_PC;
    end else if (Req) begin
      em    <= '0;
      em.pc <= EXC_PC;
    end else if (bubble_E) begin
      // Keep PC/Delay so the macro-PC seen by CP0 stays valid across stalls
      em       <= '0;
      em.pc    <= PCn_E_i;
      em.delay <= Delay_E_i;
    end else begin
      em.delay     <= Delay_E_i;
      em.exc_code  <= ExcCode_E_i;
      em.result    <= result_E_i;
      em.addr_ovf  <= addr_ovf_E_i;
      em.rd2       <= RD2_E_i;
      em.pc        <= PCn_E_i;
      em.reg_write <= regWrite_E_i;
      em.a3        <= A3_E_i;
      em.mem_rd    <= mem_rd_E_i;
      em.mem_wr    <= mem_wr_E_i;
      em.mem_type  <= mem_type_t'(mem_type_E_i);
      em.ld_signed <= ld_signed_E_i;
    end
  end

  logic [31:0] addr;
  logic [31:0] store_data;
  logic        is_half, is_byte;
  logic        in_dm, in_tc0, in_tc1, in_ig, in_dev;
  logic        misaligned, bad_addr, count_wr;
  logic [4:0]  mem_exc;
  logic [3:0]  be_raw;

  assign addr       = em.result;
  assign store_data = RD2_M_fwd ? W_forward : em.rd2;
  assign is_half    = (em.mem_type == MT_HALF);
  assign is_byte    = (em.mem_type == MT_BYTE);

  assign in_dm  = (addr < DM_END);
  assign in_tc0 = in_window(addr, TC0_BASE, TC_SPAN);
  assign in_tc1 = in_window(addr, TC1_BASE, TC_SPAN);
  assign in_ig  = in_window(addr, IG_BASE, IG_SPAN);
  assign in_dev = in_tc0 | in_tc1 | in_ig;

  // Devices are word-only; the Count register sits at word offset 2 of a timer
  assign misaligned = is_byte ? 1'b0 : (is_half ? addr[0] : (addr[1:0] != 2'b00));
  assign bad_addr   = em.addr_ovf | misaligned | ~(in_dm | in_dev) |
                      (in_dev & (is_half | is_byte));
  assign count_wr   = (in_tc0 | in_tc1) & (addr[3:2] == 2'b10);

  always_comb begin
    mem_exc = EXC_NONE;
    if (em.mem_rd && bad_addr)
      mem_exc = EXC_ADEL;
    else if (em.mem_wr && (bad_addr || count_wr))
      mem_exc = EXC_ADES;
  end

  assign ExcCode_M_o = (em.exc_code != EXC_NONE) ? em.exc_code : mem_exc;

  always_comb begin
    m_data_wdata = store_data;
    be_raw       = 4'b1111;
    if (is_half) begin
      m_data_wdata = {2{store_data[15:0]}};
      be_raw       = addr[1] ? 4'b1100 : 4'b0011;
    end else if (is_byte) begin
      m_data_wdata = {4{store_data[7:0]}};
      be_raw       = 4'b0001 << addr[1:0];
    end
  end

  assign m_data_byteen = (Req || (ExcCode_M_o != EXC_NONE) || !em.mem_wr) ? 4'b0000 : be_raw;

  memory_stage_data_ext u_data_ext (
    .addr_low  (addr[1:0]),
    .mem_type  (em.mem_type),
    .ld_signed (em.ld_signed),
    .rdata     (m_data_rdata),
    .ld_data   (ld_data_M_o)
  );

  assign m_data_addr  = addr;
  assign m_inst_addr  = em.pc;
  assign result_M_o   = em.result;
  assign mem_rd_M_o   = em.mem_rd;
  assign Delay_M_o    = em.delay;
  assign PCn_M_o      = em.pc;
  assign regWrite_M_o = em.reg_write;
  assign A3_M_o       = em.a3;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// tb_memory_stage : vector table, directed pipeline sequences, random vs model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset, Req, bubble_E, Delay_E_i;
  logic [4:0]  ExcCode_E_i, A3_E_i;
  logic [31:0] result_E_i, RD2_E_i, PCn_E_i, W_forward, m_data_rdata;
  logic        addr_ovf_E_i, regWrite_E_i, mem_rd_E_i, mem_wr_E_i, ld_signed_E_i, RD2_M_fwd;
  logic [1:0]  mem_type_E_i;
  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, result_M_o, ld_data_M_o, PCn_M_o;
  logic [3:0]  m_data_byteen;
  logic        mem_rd_M_o, Delay_M_o, regWrite_M_o;
  logic [4:0]  A3_M_o, ExcCode_M_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .reset(reset), .Req(Req), .bubble_E(bubble_E), .Delay_E_i(Delay_E_i),
    .ExcCode_E_i(ExcCode_E_i), .result_E_i(result_E_i), .addr_ovf_E_i(addr_ovf_E_i),
    .RD2_E_i(RD2_E_i), .PCn_E_i(PCn_E_i), .regWrite_E_i(regWrite_E_i), .A3_E_i(A3_E_i),
    .mem_rd_E_i(mem_rd_E_i), .mem_wr_E_i(mem_wr_E_i), .mem_type_E_i(mem_type_E_i),
    .ld_signed_E_i(ld_signed_E_i), .W_forward(W_forward), .RD2_M_fwd(RD2_M_fwd),
    .m_data_rdata(m_data_rdata), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .result_M_o(result_M_o),
    .ld_data_M_o(ld_data_M_o), .mem_rd_M_o(mem_rd_M_o), .Delay_M_o(Delay_M_o),
    .PCn_M_o(PCn_M_o), .regWrite_M_o(regWrite_M_o), .A3_M_o(A3_M_o), .ExcCode_M_o(ExcCode_M_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: derives everything from access size, lane offset and the address map
  task automatic ref_model(input logic [31:0] addr, input logic ovf, input logic [1:0] mt,
                           input logic rd, input logic wr, input logic sgn,
                           input logic [4:0] excin, input logic [31:0] sd,
                           input logic [31:0] rdata, input logic req,
                           output logic [3:0] be, output logic [31:0] wd,
                           output logic [4:0] exc, output logic [31:0] ld);
    int unsigned size, ofs, lane;
    logic dm, dev, cnt, bad;
    logic [31:0] bases [3];
    int unsigned spans [3];
    logic [63:0] v, mask;
    logic [4:0] mexc;
    bases[0] = 32'h7F00; bases[1] = 32'h7F10; bases[2] = 32'h7F20;
    spans[0] = 12; spans[1] = 12; spans[2] = 4;
    size = (mt == 2'd0) ? 4 : (mt == 2'd1) ? 2 : 1;
    ofs  = addr % 4;
    lane = ofs - (ofs % size);
    dm   = addr < 32'h3000;
    dev  = 1'b0;
    cnt  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (addr >= bases[i] && (addr - bases[i]) < spans[i]) begin
        dev = 1'b1;
        if (spans[i] == 12 && (addr - bases[i]) / 4 == 2) cnt = 1'b1;
      end
    end
    bad  = ovf || (ofs % size != 0) || !(dm || dev) || (dev && size != 4);
    mexc = (rd && bad) ? 5'd4 : (wr && (bad || cnt)) ? 5'd5 : 5'd0;
    exc  = (excin != 0) ? excin : mexc;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = sd[8*(i % size) +: 8];
      be[i] = (i >= lane) && (i < lane + size);
    end
    if (req || exc != 0 || !wr) be = 4'b0000;
    mask = (64'd1 << (8 * size)) - 64'd1;
    v = ({32'd0, rdata} >> (8 * lane)) & mask;
    if (sgn && size < 4 && v[8*size-1]) v = v | ~mask;
    ld = v[31:0];
  endtask

  task automatic set_e(input logic [31:0] addr, input logic [1:0] mt, input logic rd,
                       input logic wr, input logic sgn, input logic [4:0] excin,
                       input logic [31:0] rd2, input logic ovf);
    result_E_i = addr; mem_type_E_i = mt; mem_rd_E_i = rd; mem_wr_E_i = wr;
    ld_signed_E_i = sgn; ExcCode_E_i = excin; RD2_E_i = rd2; addr_ovf_E_i = ovf;
  endtask

  typedef struct {
    logic [31:0] addr; logic [1:0] mt; logic rd, wr, sgn, fwd; logic [4:0] excin;
    logic [31:0] rd2, wfwd, rdata; logic [3:0] be; logic [31:0] wd; logic [4:0] exc;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld, sd;
    logic [4:0]  e_exc;
    logic [31:0] r_addr, r_rd2, r_pc, r_rdata, r_wf;
    logic [1:0]  r_mt;
    logic        r_rd, r_wr, r_sgn, r_ovf, r_bub, r_dly, r_rw, r_fwd;
    logic [4:0]  r_exc, r_a3;

    tbl[0]  = '{32'h104,  2'd0, 0, 1, 0, 0, 5'd0,  32'hDEADBEEF, 32'h0, 32'h0,        4'hF, 32'hDEADBEEF, 5'd0,  32'h0};
    tbl[1]  = '{32'h102,  2'd2, 0, 1, 0, 0, 5'd0,  32'h12345678, 32'h0, 32'h0,        4'h4, 32'h78787878, 5'd0,  32'h0};
    tbl[2]  = '{32'h102,  2'd1, 0, 1, 0, 0, 5'd0,  32'h12345678, 32'h0, 32'h0,        4'hC, 32'h56785678, 5'd0,  32'h0};
    tbl[3]  = '{32'h103,  2'd2, 1, 0, 1, 0, 5'd0,  32'h0,        32'h0, 32'h80FF0000, 4'h0, 32'h0,        5'd0,  32'hFFFFFF80};
    tbl[4]  = '{32'h103,  2'd2, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0, 32'h80FF0000, 4'h0, 32'h0,        5'd0,  32'h00000080};
    tbl[5]  = '{32'h102,  2'd1, 1, 0, 1, 0, 5'd0,  32'h0,        32'h0, 32'h80FF0000, 4'h0, 32'h0,        5'd0,  32'hFFFF80FF};
    tbl[6]  = '{32'h002,  2'd0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0, 32'h0,        4'h0, 32'h0,        5'd4,  32'h0};
    tbl[7]  = '{32'h7F08, 2'd0, 0, 1, 0, 0, 5'd0,  32'h11111111, 32'h0, 32'h0,        4'h0, 32'h11111111, 5'd5,  32'h0};
    tbl[8]  = '{32'h7F00, 2'd1, 0, 1, 0, 0, 5'd0,  32'h0000ABCD, 32'h0, 32'h0,        4'h0, 32'hABCDABCD, 5'd5,  32'h0};
    tbl[9]  = '{32'h5000, 2'd0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0, 32'h0,        4'h0, 32'h0,        5'd4,  32'h0};
    tbl[10] = '{32'h001,  2'd0, 1, 0, 0, 0, 5'd10, 32'h0,        32'h0, 32'h0,        4'h0, 32'h0,        5'd10, 32'h0};
    tbl[11] = '{32'h7F00, 2'd0, 0, 1, 0, 0, 5'd0,  32'h00000001, 32'h0, 32'h0,        4'hF, 32'h00000001, 5'd0,  32'h0};
    tbl[12] = '{32'h3000, 2'd0, 0, 1, 0, 0, 5'd0,  32'h55AA55AA, 32'h0, 32'h0,        4'h0, 32'h55AA55AA, 5'd5,  32'h0};
    tbl[13] = '{32'h100,  2'd1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0, 32'h12348765, 4'h0, 32'h0,        5'd0,  32'h00008765};
    tbl[14] = '{32'h2FFC, 2'd0, 0, 1, 0, 1, 5'd0,  32'h0,  32'hCAFEF00D, 32'h0,        4'hF, 32'hCAFEF00D, 5'd0,  32'h0};
    tbl[15] = '{32'h7F20, 2'd0, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0, 32'h00000003, 4'h0, 32'h0,        5'd0,  32'h00000003};
    tbl[16] = '{32'h7F12, 2'd2, 0, 1, 0, 0, 5'd0,  32'h000000EE, 32'h0, 32'h0,        4'h0, 32'hEEEEEEEE, 5'd5,  32'h0};

    reset = 1; Req = 0; bubble_E = 0; Delay_E_i = 0; PCn_E_i = 32'h3000;
    regWrite_E_i = 0; A3_E_i = 0; W_forward = 0; RD2_M_fwd = 0; m_data_rdata = 0;
    set_e(32'h0, 2'd0, 0, 0, 0, 5'd0, 32'h0, 0);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset_pc", PCn_M_o, 32'h3000);
    chk("reset_inst_addr", m_inst_addr, 32'h3000);
    chk("reset_regwrite", {31'd0, regWrite_M_o}, 32'd0);
    chk("reset_exc", {27'd0, ExcCode_M_o}, 32'd0);
    chk("reset_be", {28'd0, m_data_byteen}, 32'd0);
    chk("reset_delay", {31'd0, Delay_M_o}, 32'd0);
    chk("reset_memrd", {31'd0, mem_rd_M_o}, 32'd0);
    chk("reset_result", result_M_o, 32'd0);
    @(negedge clk); reset = 0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      set_e(tbl[i].addr, tbl[i].mt, tbl[i].rd, tbl[i].wr, tbl[i].sgn, tbl[i].excin, tbl[i].rd2, 0);
      RD2_M_fwd = tbl[i].fwd; W_forward = tbl[i].wfwd; m_data_rdata = tbl[i].rdata;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_be", i), {28'd0, m_data_byteen}, {28'd0, tbl[i].be});
      chk($sformatf("vec%0d_wdata", i), m_data_wdata, tbl[i].wd);
      chk($sformatf("vec%0d_exc", i), {27'd0, ExcCode_M_o}, {27'd0, tbl[i].exc});
      chk($sformatf("vec%0d_addr", i), m_data_addr, tbl[i].addr);
      if (tbl[i].rd && tbl[i].exc == 0)
        chk($sformatf("vec%0d_ld", i), ld_data_M_o, tbl[i].ld);
    end
    RD2_M_fwd = 0;

    // Req while a store sits in M: write suppressed now, bubble at EXC_PC next
    @(negedge clk);
    set_e(32'h104, 2'd0, 0, 1, 0, 5'd0, 32'hDEADBEEF, 0);
    PCn_E_i = 32'h3020; regWrite_E_i = 1; A3_E_i = 5'd7;
    @(posedge clk); #1;
    chk("req_pre_be", {28'd0, m_data_byteen}, 32'hF);
    Req = 1; #1;
    chk("req_be", {28'd0, m_data_byteen}, 32'h0);
    @(posedge clk); #1;
    Req = 0; #1;
    chk("req_pc", PCn_M_o, 32'h4180);
    chk("req_regwrite", {31'd0, regWrite_M_o}, 32'd0);
    chk("req_be_after", {28'd0, m_data_byteen}, 32'h0);
    chk("req_delay", {31'd0, Delay_M_o}, 32'd0);

    // Stall bubble keeps PC/Delay but drops control and ExcCode
    @(negedge clk);
    set_e(32'h104, 2'd0, 0, 1, 0, 5'd12, 32'h1, 0);
    PCn_E_i = 32'h3010; Delay_E_i = 1; regWrite_E_i = 1; bubble_E = 1;
    @(posedge clk); #1;
    chk("bub_regwrite", {31'd0, regWrite_M_o}, 32'd0);
    chk("bub_pc", PCn_M_o, 32'h3010);
    chk("bub_delay", {31'd0, Delay_M_o}, 32'd1);
    chk("bub_exc", {27'd0, ExcCode_M_o}, 32'd0);
    chk("bub_be", {28'd0, m_data_byteen}, 32'd0);
    @(negedge clk); bubble_E = 0; Delay_E_i = 0;

    // Reset mid-stream flushes a pending store
    @(posedge clk); #1;
    chk("mid_pre_be", {28'd0, m_data_byteen}, 32'h0);
    @(negedge clk);
    set_e(32'h200, 2'd0, 0, 1, 0, 5'd0, 32'h77, 0);
    reset = 1;
    @(posedge clk); #1;
    chk("mid_reset_pc", PCn_M_o, 32'h3000);
    chk("mid_reset_be", {28'd0, m_data_byteen}, 32'h0);
    @(negedge clk); reset = 0;

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: r_addr = $urandom_range(0, 32'h2FFF);
        1: r_addr = 32'h2FF8 + $urandom_range(0, 15);
        2: r_addr = 32'h7EFC + $urandom_range(0, 47);
        default: r_addr = $urandom;
      endcase
      r_mt = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0: begin r_rd = 0; r_wr = 0; end
        1: begin r_rd = 1; r_wr = 0; end
        default: begin r_rd = 0; r_wr = 1; end
      endcase
      r_sgn = 1'($urandom_range(0, 1));
      r_ovf = ($urandom_range(0, 15) == 0);
      r_exc = ($urandom_range(0, 7) == 0) ? 5'd12 : 5'd0;
      r_bub = ($urandom_range(0, 9) == 0);
      r_dly = 1'($urandom_range(0, 1));
      r_rw  = 1'($urandom_range(0, 1));
      r_a3  = 5'($urandom);
      r_pc  = 32'h3000 + ($urandom_range(0, 1023) << 2);
      r_rd2 = $urandom; r_wf = $urandom; r_rdata = $urandom;
      r_fwd = 1'($urandom_range(0, 1));
      set_e(r_addr, r_mt, r_rd, r_wr, r_sgn, r_exc, r_rd2, r_ovf);
      PCn_E_i = r_pc; Delay_E_i = r_dly; regWrite_E_i = r_rw; A3_E_i = r_a3; bubble_E = r_bub;
      RD2_M_fwd = r_fwd; W_forward = r_wf; m_data_rdata = r_rdata;
      sd = r_fwd ? r_wf : r_rd2;
      @(posedge clk); #1;
      if (r_bub) begin
        chk("rnd_bub_pc", PCn_M_o, r_pc);
        chk("rnd_bub_delay", {31'd0, Delay_M_o}, {31'd0, r_dly});
        chk("rnd_bub_rw", {31'd0, regWrite_M_o}, 32'd0);
        chk("rnd_bub_exc", {27'd0, ExcCode_M_o}, 32'd0);
        chk("rnd_bub_be", {28'd0, m_data_byteen}, 32'd0);
      end else begin
        ref_model(r_addr, r_ovf, r_mt, r_rd, r_wr, r_sgn, r_exc, sd, r_rdata, 1'b0,
                  e_be, e_wd, e_exc, e_ld);
        chk("rnd_be", {28'd0, m_data_byteen}, {28'd0, e_be});
        chk("rnd_wdata", m_data_wdata, e_wd);
        chk("rnd_exc", {27'd0, ExcCode_M_o}, {27'd0, e_exc});
        if (r_rd && e_exc == 0) chk("rnd_ld", ld_data_M_o, e_ld);
        chk("rnd_pc", m_inst_addr, r_pc);
        chk("rnd_result", result_M_o, r_addr);
        chk("rnd_rw", {31'd0, regWrite_M_o}, {31'd0, r_rw});
        chk("rnd_a3", {27'd0, A3_M_o}, {27'd0, r_a3});
        chk("rnd_memrd", {31'd0, mem_rd_M_o}, {31'd0, r_rd});
        chk("rnd_delay", {31'd0, Delay_M_o}, {31'd0, r_dly});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
